// File: rtl/shift_right_seq_if.sv
// Handshake and data bundle for shift_right_seq.
//   start : request from the execute stage, sampled only when busy=0
//   In    : operand, captured on the accepted start
//   Cnt   : shift amount 0..N-1, captured on the accepted start
//   Mode  : 00 logical, 01 arithmetic, 10 rotate right, 11 behaves as 00
//   busy  : shifter occupied (cycle after accept through the done cycle)
//   done  : one-cycle pulse, Out valid in that cycle
//   Out   : result register, holds until the next accepted start
// master drives the request side; slave is the shifter.
interface shift_right_seq_if #(
    parameter int N = 16,
    parameter int C = 4
);
    logic         start;
    logic [N-1:0] In;
    logic [C-1:0] Cnt;
    logic [1:0]   Mode;
    logic         busy;
    logic         done;
    logic [N-1:0] Out;

    modport master (
        output start, In, Cnt, Mode,
        input  busy, done, Out
    );

    modport slave (
        input  start, In, Cnt, Mode,
        output busy, done, Out
    );
endinterface

// File: rtl/shift_right_seq.sv
// Multi-cycle right shifter, one bit position per clock, with logical,
// arithmetic and rotate modes and a start/busy/done handshake.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset, wins over everything
//   bus : shift_right_seq_if slave modport (start/In/Cnt/Mode in,
//         busy/done/Out out)
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; busy=0, done=0
// SHIFT | one right shift per edge until count reaches 1; busy=1
// DONE  | result valid, done pulse; start ignored; back to IDLE
module shift_right_seq #(
    parameter int N = 16,
    parameter int C = 4
) (
    input  logic               clk,
    input  logic               rst,
    shift_right_seq_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [C-1:0] COUNT_ONE = {{(C-1){1'b0}}, 1'b1};

    state_t       state;
    state_t       state_nx;
    logic [N-1:0] result_r;
    logic [C-1:0] count;
    logic [1:0]   mode_r;
    logic         fill;
    logic         busy_c;
    logic         done_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx = (bus.Cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count == COUNT_ONE) begin
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_c = 1'b0;
        done_c = 1'b0;
        case (state)
            SHIFT: busy_c = 1'b1;
            DONE: begin
                busy_c = 1'b1;
                done_c = 1'b1;
            end
            default: begin
                busy_c = 1'b0;
                done_c = 1'b0;
            end
        endcase
    end

    // Bit entering at the MSB; the reserved mode falls back to zero fill.
    always_comb begin
        case (mode_r)
            2'b01:   fill = result_r[N-1];
            2'b10:   fill = result_r[0];
            default: fill = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= '0;
            count    <= '0;
            mode_r   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        result_r <= bus.In;
                        count    <= bus.Cnt;
                        mode_r   <= bus.Mode;
                    end
                end
                SHIFT: begin
                    // SHIFT is only entered with count>=1, so this never wraps.
                    result_r <= {fill, result_r[N-1:1]};
                    count    <= count - COUNT_ONE;
                end
                default: begin
                    result_r <= result_r;
                    count    <= count;
                end
            endcase
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;
    assign bus.Out  = result_r;

endmodule

// File: tb/tb_shift_right_seq.sv
module tb_shift_right_seq;

    logic clk;
    logic rst;

    shift_right_seq_if #(.N(16), .C(4)) bus ();

    shift_right_seq #(.N(16), .C(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    // Reference model: tracks the accepted operation and its age in cycles.
    bit          m_active = 1'b0;
    int          m_age    = 0;
    logic [15:0] m_in     = '0;
    int          m_cnt    = 0;
    logic [1:0]  m_mode   = 2'b00;

    function automatic logic [15:0] ref_shift(logic [15:0] x, int k, logic [1:0] m);
        logic [31:0] d;
        case (m)
            2'b01: return 16'($signed(x) >>> k);
            2'b10: begin
                d = {x, x};
                d = d >> k;
                return d[15:0];
            end
            default: return x >> k;
        endcase
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_active = 1'b0;
            m_age    = 0;
        end else if ((!m_active || m_age > m_cnt + 1) && bus.start) begin
            m_active = 1'b1;
            m_age    = 1;
            m_in     = bus.In;
            m_cnt    = int'(bus.Cnt);
            m_mode   = bus.Mode;
        end else if (m_active && m_age < 1000) begin
            m_age++;
        end
    end

    always @(negedge clk) begin
        logic        e_busy;
        logic        e_done;
        logic [15:0] e_out;
        int          k;
        if (chk_en) begin
            e_busy = m_active && (m_age <= m_cnt + 1);
            e_done = m_active && (m_age == m_cnt + 1);
            k      = (m_age - 1 < m_cnt) ? m_age - 1 : m_cnt;
            e_out  = m_active ? ref_shift(m_in, k, m_mode) : 16'h0000;
            check("model_busy", {15'b0, bus.busy}, {15'b0, e_busy});
            check("model_done", {15'b0, bus.done}, {15'b0, e_done});
            check("model_out", bus.Out, e_out);
        end
    end

    // Called just after the accepting edge; checks latency and result.
    task automatic wait_done(input string name, input int cnt, input logic [15:0] exp_out);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        repeat (40) begin
            @(negedge clk);
            lat++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout actual=no_done required=done", name);
        end else begin
            check({name, "_lat"}, 16'(lat), 16'(cnt + 1));
            check({name, "_out"}, bus.Out, exp_out);
        end
    endtask

    task automatic run_op(input string name, input logic [15:0] in, input logic [3:0] cnt,
                          input logic [1:0] mode, input logic [15:0] exp_out);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.In    = in;
        bus.Cnt   = cnt;
        bus.Mode  = mode;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.In    = 16'($urandom);
        bus.Cnt   = 4'($urandom);
        bus.Mode  = 2'($urandom);
        wait_done(name, int'(cnt), exp_out);
    endtask

    initial begin
        int n;
        bit got;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.In    = '0;
        bus.Cnt   = '0;
        bus.Mode  = 2'b00;
        @(posedge clk);
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out", bus.Out, 16'h0000);
        check("reset_busy", {15'b0, bus.busy}, 16'h0000);
        check("reset_done", {15'b0, bus.done}, 16'h0000);

        // Reset in the middle of a long shift, then start right away.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.In    = 16'hFFFF;
        bus.Cnt   = 4'd15;
        bus.Mode  = 2'b00;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b1;
        bus.In    = 16'h00F0;
        bus.Cnt   = 4'd2;
        bus.Mode  = 2'b00;
        @(negedge clk);
        check("t1_out", bus.Out, 16'h0000);
        check("t1_busy", {15'b0, bus.busy}, 16'h0000);
        check("t1_done", {15'b0, bus.done}, 16'h0000);
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done("t1_restart", 2, 16'h003C);

        run_op("t2_logical", 16'h8001, 4'd4, 2'b00, 16'h0800);
        run_op("t3_arith_a", 16'h8000, 4'd15, 2'b01, 16'hFFFF);
        run_op("t3_arith_b", 16'h4000, 4'd14, 2'b01, 16'h0001);
        run_op("t4_rot_a", 16'h0001, 4'd1, 2'b10, 16'h8000);
        run_op("t4_rot_b", 16'h1234, 4'd8, 2'b10, 16'h3412);
        run_op("t5_zero_a", 16'hABCD, 4'd0, 2'b01, 16'hABCD);
        run_op("t5_zero_b", 16'hABCD, 4'd0, 2'b11, 16'hABCD);
        run_op("reserved", 16'h8000, 4'd3, 2'b11, 16'h1000);

        // Start held high while In toggles; only the first operand counts.
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.In    = 16'hF000;
        bus.Cnt   = 4'd3;
        bus.Mode  = 2'b00;
        got = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1 bus.In = 16'($urandom);
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL t6_first timeout actual=no_done required=done");
        end
        check("t6_first_out", bus.Out, 16'h1E00);
        bus.In   = 16'h00FF;
        bus.Cnt  = 4'd1;
        bus.Mode = 2'b10;
        n   = 0;
        got = 1'b0;
        repeat (40) begin
            @(negedge clk);
            n++;
            if (bus.done) begin
                got = 1'b1;
                break;
            end
        end
        bus.start = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL t6_second timeout actual=no_done required=done");
        end
        check("t6_second_gap", 16'(n), 16'd3);
        check("t6_second_out", bus.Out, 16'h807F);

        // Random traffic, including held starts and occasional resets.
        repeat (3000) begin
            @(posedge clk);
            #1;
            rst       = ($urandom_range(0, 249) == 0);
            bus.start = ($urandom_range(0, 3) != 0);
            bus.In    = 16'($urandom);
            bus.Cnt   = 4'($urandom_range(0, 15));
            bus.Mode  = 2'($urandom_range(0, 3));
        end
        @(posedge clk);
        #1;
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
